// File: rtl/uart_pkg.sv
// Shared pacing constants and state encoding for the UART transmit feeder.
// A frame is 12 bit-times at 4 clocks per bit-time for each clock-divide step.
package uart_pkg;

  localparam int BITS_PER_FRAME = 12;
  localparam int OVERSAMPLE     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } feeder_state_t;

  function automatic int calc_clock_divide(input int clockfrq, input int baudrate);
    return clockfrq / (baudrate * OVERSAMPLE);
  endfunction

  function automatic int calc_frame_clks(input int clock_divide);
    return BITS_PER_FRAME * OVERSAMPLE * clock_divide;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with a registered fill level and single-cycle flush.
// The head byte is presented combinationally so a pop captures it on the same edge.
module sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wr_data,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Flush outranks push and pop so the queue reads empty on the very next cycle.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds buffered bytes to a downstream UART, one transmit strobe per frame time.
// The FIFO absorbs producer bursts; the state machine enforces the inter-frame gap.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int CLOCKFRQ = 240000000,
  parameter int BAUDRATE = 12000000,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   flush,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             tx_byte,
  output logic                   transmit,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);

  localparam int CLOCK_DIVIDE = calc_clock_divide(CLOCKFRQ, BAUDRATE);
  localparam int FRAME_CLKS   = calc_frame_clks(CLOCK_DIVIDE);
  localparam int LW           = $clog2(DEPTH) + 1;
  localparam int GW           = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(FRAME_CLKS - 1);

  feeder_state_t state;
  feeder_state_t state_next;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_next;
  logic [7:0]    fifo_head;
  logic          push;
  logic          pop;
  logic          load_byte;

  // Ready is held low through reset so nothing is offered to a FIFO being cleared.
  assign in_ready = nRst && (fifo_level != LW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign busy     = (fifo_level != '0) || (state != IDLE);

  sync_fifo #(
    .DEPTH(DEPTH)
  ) fifo (
    .clk     (clk),
    .nRst    (nRst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (fifo_head),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      tx_byte <= 8'h00;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
      if (load_byte) begin
        tx_byte <= fifo_head;
      end
    end
  end

  // GAP exits as the counter reaches zero, giving FRAME_CLKS+2 cycles strobe to strobe.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    pop        = 1'b0;
    load_byte  = 1'b0;
    transmit   = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (fifo_level != '0) begin
          pop        = 1'b1;
          load_byte  = 1'b1;
          state_next = STROBE;
        end else begin
          state_next = IDLE;
        end
      end
      STROBE: begin
        transmit   = 1'b1;
        gap_next   = GAP_RELOAD;
        state_next = GAP;
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) begin
          gap_next   = '0;
          state_next = IDLE;
        end else begin
          gap_next = gap_cnt - GW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder at default parameters.
// Accepted bytes are queued at the handshake and matched against each transmit strobe.
module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int FRAME   = 240;
  localparam int SPACING = FRAME + 2;

  logic       clk = 1'b0;
  logic       nRst;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_byte;
  logic       transmit;
  logic [4:0] fifo_level;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  int         strobe_cyc[$];

  uart_tx_feeder #(
    .CLOCKFRQ(240000000),
    .BAUDRATE(12000000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_byte    (tx_byte),
    .transmit   (transmit),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic fl);
    in_valid = valid;
    in_data  = data;
    flush    = fl;
    tick();
  endtask

  task automatic waitIdle(input int budget, output int idle_cyc);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput("idle_reached", 32'(busy), 32'd0);
    idle_cyc = cyc;
  endtask

  task automatic waitStrobes(input int target, input int budget);
    int n;
    n = 0;
    while (strobe_cyc.size() < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("strobe_count", strobe_cyc.size(), target);
  endtask

  // Scoreboard: strobes are checked before this cycle's handshake is queued.
  always @(negedge clk) begin
    logic [7:0] exp_byte;
    if (!nRst) begin
      exp_q.delete();
    end else begin
      if (transmit) begin
        strobe_cyc.push_back(cyc);
        checkOutput("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_byte = exp_q.pop_front();
          checkOutput("strobe_byte", 32'(tx_byte), 32'(exp_byte));
        end
      end
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, observed running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         idle_cyc;
    int         n_acc;
    int         n_base;
    int         s_last;
    int         gap_a;
    int         gap_b;
    logic [7:0] pat;
    logic       acc;
    logic       any_tx;

    nRst     = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    $display("[TB] reset state");
    checkOutput("rst_transmit", 32'(transmit), 32'd0);
    checkOutput("rst_tx_byte", 32'(tx_byte), 32'h00);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    nRst = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] single byte latency");
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    checkOutput("a5_level_c0", 32'(fifo_level), 32'd1);
    checkOutput("a5_tx_c0", 32'(transmit), 32'd0);
    tick();
    checkOutput("a5_tx_c1", 32'(transmit), 32'd0);
    tick();
    checkOutput("a5_tx_c2", 32'(transmit), 32'd1);
    checkOutput("a5_byte_c2", 32'(tx_byte), 32'hA5);
    checkOutput("a5_level_c2", 32'(fifo_level), 32'd0);
    tick();
    checkOutput("a5_tx_c3", 32'(transmit), 32'd0);
    waitIdle(SPACING * 2, idle_cyc);

    $display("[TB] three byte burst spacing");
    n_base = strobe_cyc.size();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
    end
    in_valid = 1'b0;
    waitStrobes(n_base + 3, 4 * SPACING);
    gap_a = -1;
    gap_b = -1;
    if (strobe_cyc.size() >= n_base + 3) begin
      gap_a = strobe_cyc[n_base + 1] - strobe_cyc[n_base];
      gap_b = strobe_cyc[n_base + 2] - strobe_cyc[n_base + 1];
    end
    checkOutput("burst_gap_1", gap_a, SPACING);
    checkOutput("burst_gap_2", gap_b, SPACING);
    waitIdle(2 * SPACING, idle_cyc);
    checkOutput("burst_strobe_total", strobe_cyc.size(), n_base + 3);

    $display("[TB] backpressure when full");
    n_acc = 0;
    pat   = 8'h10;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = pat;
      acc      = in_ready;
      tick();
      if (acc) begin
        pat++;
        n_acc++;
      end
    end
    checkOutput("fill_accepted", n_acc, 17);
    checkOutput("fill_level", 32'(fifo_level), DEPTH);
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    n_acc = 0;
    for (int i = 0; i < 260; i++) begin
      in_valid = 1'b1;
      in_data  = pat;
      acc      = in_ready;
      tick();
      if (acc) begin
        pat++;
        n_acc++;
      end
    end
    in_valid = 1'b0;
    checkOutput("refill_accepted", n_acc, 1);
    checkOutput("refill_level", 32'(fifo_level), DEPTH);

    $display("[TB] flush during gap");
    s_last = strobe_cyc[strobe_cyc.size() - 1];
    n_base = strobe_cyc.size();
    applyStimulus(1'b0, 8'h00, 1'b1);
    flush = 1'b0;
    checkOutput("flush_level", 32'(fifo_level), 32'd0);
    checkOutput("flush_busy_in_gap", 32'(busy), 32'd1);
    waitIdle(2 * SPACING, idle_cyc);
    checkOutput("flush_gap_end", idle_cyc - s_last, FRAME);
    repeat (SPACING) tick();
    checkOutput("flush_no_strobe", strobe_cyc.size(), n_base);

    $display("[TB] reset during gap");
    pat = 8'h60;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, pat, 1'b0);
      pat++;
    end
    in_valid = 1'b0;
    repeat (50) tick();
    checkOutput("pre_reset_level", 32'(fifo_level), 32'd5);
    n_base = strobe_cyc.size();
    #2;
    nRst = 1'b0;
    #1;
    checkOutput("mid_reset_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_reset_transmit", 32'(transmit), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_reset_tx_byte", 32'(tx_byte), 32'h00);
    any_tx = 1'b0;
    repeat (20) begin
      tick();
      any_tx = any_tx | transmit;
    end
    checkOutput("reset_hold_no_tx", 32'(any_tx), 32'd0);
    nRst = 1'b1;
    repeat (SPACING + 10) tick();
    checkOutput("post_reset_no_strobe", strobe_cyc.size(), n_base);
    checkOutput("post_reset_idle", 32'(busy), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("3c_tx_c1", 32'(transmit), 32'd0);
    tick();
    checkOutput("3c_tx_c2", 32'(transmit), 32'd1);
    checkOutput("3c_byte_c2", 32'(tx_byte), 32'h3C);
    waitIdle(2 * SPACING, idle_cyc);

    $display("[TB] pointer wrap with 40 bytes");
    n_base = strobe_cyc.size();
    n_acc  = 0;
    pat    = 8'h80;
    for (int i = 0; i < 15000 && n_acc < 40; i++) begin
      in_valid = 1'b1;
      in_data  = pat;
      acc      = in_ready;
      tick();
      if (acc) begin
        pat++;
        n_acc++;
      end
    end
    in_valid = 1'b0;
    checkOutput("wrap_accepted", n_acc, 40);
    waitStrobes(n_base + 40, 20 * SPACING);
    checkOutput("wrap_queue_drained", exp_q.size(), 0);
    waitIdle(2 * SPACING, idle_cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter CLOCKFRQ, default 240000000, master clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 12000000, serial baud rate in Hz.
REQ-003 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, 2..256.
REQ-004 Derived constant CLOCK_DIVIDE = CLOCKFRQ/(BAUDRATE*4); FRAME_CLKS = 12*4*CLOCK_DIVIDE (240 at defaults); LW = $clog2(DEPTH)+1.
REQ-005 Port clk  input  1  master clock; every flop on its rising edge.
REQ-006 Port nRst  input  1  reset, asynchronous assert, active-low.
REQ-007 Port flush  input  1  synchronous FIFO discard.
REQ-008 Port in_data  input  8  byte offered by the upstream producer.
REQ-009 Port in_valid  input  1  in_data valid.
REQ-010 Port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-011 Port tx_byte  output  8  byte presented to the downstream uart tx_byte input.
REQ-012 Port transmit  output  1  one-cycle strobe to the downstream uart transmit input.
REQ-013 Port fifo_level  output  LW  bytes currently stored.
REQ-014 Port busy  output  1  high when the FIFO is non-empty or state is not IDLE.

Function
REQ-015 Push occurs on any cycle with in_valid && in_ready; in_ready SHALL equal (fifo_level != DEPTH) && !flush, registered-free (combinational from the level).
REQ-016 A push and a pop in the same cycle SHALL leave fifo_level unchanged; a push when full SHALL NOT occur, even if a pop occurs in the same cycle.
REQ-017 FIFO pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; fifo_level SHALL span 0..DEPTH.
REQ-018 State machine states: IDLE, LOAD, STROBE, GAP.
REQ-019 IDLE: if fifo_level != 0, go to LOAD; otherwise stay.
REQ-020 LOAD: pop the head byte into the tx_byte register; go to STROBE.
REQ-021 STROBE: transmit = 1 for exactly this cycle; load the gap counter with FRAME_CLKS-1; go to GAP.
REQ-022 GAP: decrement the counter each cycle; at 0, go to IDLE. IDLE with data pending SHALL go directly to LOAD, giving a minimum strobe-to-strobe spacing of FRAME_CLKS+2 cycles.
REQ-023 transmit SHALL be 0 in every state except STROBE.
REQ-024 tx_byte SHALL be stable from the LOAD-exit edge until the next LOAD.
REQ-025 Latency: a byte pushed into an empty FIFO at cycle N while in IDLE SHALL see transmit high at cycle N+2, with that byte on tx_byte.
REQ-026 flush SHALL clear the FIFO pointers and level in one cycle and push nothing that cycle. A byte already in the tx_byte register SHALL still complete STROBE and GAP.
REQ-027 Gap counter width SHALL be $clog2(FRAME_CLKS) bits; no other arithmetic wider than LW.

Reset
REQ-028 While nRst is low: state = IDLE, pointers = 0, fifo_level = 0, transmit = 0, tx_byte = 8'h00, gap counter = 0, busy = 0; in_ready SHALL be 0 during reset.
REQ-029 Reset asserted mid-GAP or mid-STROBE SHALL abort immediately: no further strobe, and FIFO contents are lost.
REQ-030 After nRst deasserts, in_ready SHALL be 1 on the first clock edge.

Structure
REQ-031 A shared package uart_pkg SHALL hold the state enumeration, the CLOCK_DIVIDE/FRAME_CLKS derivation and the bits-per-frame constant 12.
REQ-032 Storage SHALL be one sub-module, sync_fifo (parameter DEPTH, 8-bit width, push/pop/flush, level output); the pacing state machine stays in uart_tx_feeder.

Verification
REQ-033 Reset, then push 8'hA5 at cycle 0 -> transmit high at cycle 2 only, tx_byte = 8'hA5, fifo_level back to 0 at cycle 2.
REQ-034 Push 8'h01..8'h03 back-to-back -> three strobes spaced exactly 242 cycles apart (defaults), bytes 01, 02, 03 in order.
REQ-035 Hold in_valid high with no pops pending beyond the first -> in_ready drops after 17 accepted bytes (16 stored + 1 loaded). Each subsequent pop re-asserts in_ready for one push.
REQ-036 Fill to 16, assert flush for 1 cycle during GAP -> fifo_level = 0 next cycle; the current GAP completes; no further strobes; busy falls when GAP ends.
REQ-037 Assert nRst low mid-GAP with 5 bytes queued -> transmit stays 0, fifo_level = 0 asynchronously; after release, a push of 8'h3C strobes at +2 cycles.
REQ-038 Wrap test: push/pop 40 bytes (incrementing pattern) through DEPTH = 16 -> output order is intact across pointer wrap and there are no duplicates.
